// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pixel/state types, 640x480@60 default timing and control codes
// for video_timing_ctrl.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Control-period code for the green and red TMDS lanes; only blue carries sync.
  localparam logic [1:0] CTL_NULL = 2'b00;

  // Colour-bar order white, yellow, cyan, green, magenta, red, blue, black falls out
  // of the index bits: red drops on idx[1], green on idx[2], blue on idx[0].
  function automatic pixel_t bar_colour(input logic [2:0] idx);
    pixel_t p;
    p.r = {8{~idx[1]}};
    p.g = {8{~idx[2]}};
    p.b = {8{~idx[0]}};
    return p;
  endfunction

endpackage

// File: rtl/video_sync_counter.sv
// rtl/video_sync_counter.sv - one timing axis: wrapping position counter with
// active-region and sync-window decode.
module video_sync_counter
  import video_pkg::*;
#(
  parameter int   ACTIVE   = VGA_H_ACTIVE,
  parameter int   FP       = VGA_H_FP,
  parameter int   SYNC     = VGA_H_SYNC,
  parameter int   BP       = VGA_H_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CNT_W    = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic             clr,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             active,
  output logic             sync
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = ACTIVE + FP + SYNC;

  logic in_sync;

  assign last    = (cnt == CNT_W'(TOTAL - 1));
  assign active  = (32'(cnt) < ACTIVE);
  assign in_sync = (32'(cnt) >= SYNC_START) && (32'(cnt) < SYNC_END);
  assign sync    = in_sync ? SYNC_POL : ~SYNC_POL;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster timing and pixel pacing for a three-lane TMDS encoder.
// Optional colour-bar generator compiled in with VIDEO_TIMING_TEST_PATTERN_EN.
module video_timing_ctrl
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        enable_i,
  input  logic [23:0] pix_data_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic        vde_o,
  output logic [7:0]  vd_r_o,
  output logic [7:0]  vd_g_o,
  output logic [7:0]  vd_b_o,
  output logic [1:0]  cd_b_o,
  output logic [1:0]  cd_g_o,
  output logic [1:0]  cd_r_o,
  output logic        frame_start_o,
  output logic        busy_o,
  output logic        underflow_o,
  input  logic        clr_underflow_i,
  input  logic        pattern_sel_i
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  state_t state, state_nxt;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, h_act, v_act;
  logic          hsync, vsync;
  logic          running, active, frame_last;
  logic          pat_mode, miss;
  pixel_t        pix_in, pat_pix, pix_nxt;

  assign running    = (state != ST_IDLE);
  assign active     = h_act && v_act;
  assign frame_last = h_last && v_last;

  video_sync_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL),
    .CNT_W    (HW)
  ) u_h_cnt (
    .clk    (clk),
    .rstn_i (rstn_i),
    .clr    (!running),
    .step   (running),
    .cnt    (h_cnt),
    .last   (h_last),
    .active (h_act),
    .sync   (hsync)
  );

  video_sync_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL),
    .CNT_W    (VW)
  ) u_v_cnt (
    .clk    (clk),
    .rstn_i (rstn_i),
    .clr    (!running),
    .step   (running && h_last),
    .cnt    (v_cnt),
    .last   (v_last),
    .active (v_act),
    .sync   (vsync)
  );

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping enable on the very last pixel finishes the frame in that cycle, so RUN
  // may skip DRAIN rather than scan one more complete frame.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (enable_i) state_nxt = ST_RUN;
      ST_RUN:   if (!enable_i) state_nxt = frame_last ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (enable_i) begin
          state_nxt = ST_RUN;
        end else if (frame_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  logic [2:0] bar_idx;

  assign pat_mode = pattern_sel_i;
  assign bar_idx  = 3'((32'(h_cnt) * 8) / H_ACTIVE);
  assign pat_pix  = bar_colour(bar_idx);
`else
  logic unused_pattern_sel;

  assign pat_mode           = 1'b0;
  assign pat_pix            = '0;
  assign unused_pattern_sel = pattern_sel_i;
`endif

  assign pix_in      = pix_data_i;
  assign pix_ready_o = running && active && !pat_mode;
  assign miss        = pix_ready_o && !pix_valid_i;
  assign busy_o      = running;
  assign cd_g_o      = CTL_NULL;
  assign cd_r_o      = CTL_NULL;

  // A missing source pixel still occupies its slot on the wire, blanked to black.
  always_comb begin
    pix_nxt = '0;
    if (running && active) begin
      if (pat_mode) begin
        pix_nxt = pat_pix;
      end else if (pix_valid_i) begin
        pix_nxt = pix_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      vde_o         <= 1'b0;
      vd_r_o        <= '0;
      vd_g_o        <= '0;
      vd_b_o        <= '0;
      cd_b_o        <= {~SYNC_POL, ~SYNC_POL};
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      vde_o                      <= running && active;
      {vd_r_o, vd_g_o, vd_b_o}   <= pix_nxt;
      cd_b_o                     <= running ? {vsync, hsync} : {~SYNC_POL, ~SYNC_POL};
      frame_start_o              <= running && (h_cnt == '0) && (v_cnt == '0);
      if (miss) begin
        underflow_o <= 1'b1;
      end else if (clr_underflow_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

endmodule
